// File: rtl/f2_pkg.sv
// f2_pkg: shared FSM state type and the default F2 memory map for the CPU/SDRAM bridge.
package f2_pkg;
  typedef enum logic [2:0] {IDLE, WAITP, REQ, EXT, ACK} bridge_state_t;
  localparam int F2_NUM_REGIONS = 4;
  // ROM 0x000000/1MB, WORK 0x100000/64KB, SCN 0x800000/64KB, spare external 0xC00000/64KB
  localparam logic [95:0] F2_DEFAULT_BASE = {24'hC00000, 24'h800000, 24'h100000, 24'h000000};
  localparam logic [95:0] F2_DEFAULT_MASK = {24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hF00000};
  localparam logic [103:0] F2_DEFAULT_SDR = {26'h0, 26'h0, 26'h500000, 26'h400000};
endpackage

// File: rtl/cpu_region_decode.sv
// cpu_region_decode: priority address decoder producing the winning region and its SDRAM word address.
module cpu_region_decode #(
  parameter int NR = 4,
  parameter int IW = 2,
  parameter logic [24*NR-1:0] BASE = '0,
  parameter logic [24*NR-1:0] MASK = '0,
  parameter logic [26*NR-1:0] SDR = '0
) (
  input  logic [23:0]   addr,
  output logic [NR-1:0] hit,
  output logic [IW-1:0] idx,
  output logic [25:0]   sdr_addr,
  output logic          unmapped
);
  logic [26:0] sum;
  always_comb begin
    idx = '0;
    unmapped = 1'b1;
    sum = '0;
    // descending scan so the lowest matching index is the one left standing
    for (int i = NR - 1; i >= 0; i--) begin
      if (((addr ^ BASE[24*i +: 24]) & MASK[24*i +: 24]) == 24'd0) begin
        idx = IW'(i);
        unmapped = 1'b0;
        sum = {1'b0, SDR[26*i +: 26]} + {3'b0, addr & ~MASK[24*i +: 24]};
      end
    end
    hit = unmapped ? '0 : NR'(1) << idx;
    sdr_addr = 26'(sum >> 1);
  end
endmodule

// File: rtl/cpu_sdr_bridge.sv
// cpu_sdr_bridge: 68000 bus to SDRAM toggle-handshake bridge with region decode, DTACK
// generation and optional single posted write.
module cpu_sdr_bridge
  import f2_pkg::*;
#(
  parameter int NUM_REGIONS = F2_NUM_REGIONS,
  parameter logic [24*NUM_REGIONS-1:0] REGION_BASE = F2_DEFAULT_BASE,
  parameter logic [24*NUM_REGIONS-1:0] REGION_MASK = F2_DEFAULT_MASK,
  parameter logic [26*NUM_REGIONS-1:0] REGION_SDR = F2_DEFAULT_SDR,
  parameter logic [NUM_REGIONS-1:0] SDR_EN = 4'b0011,
  parameter logic [NUM_REGIONS-1:0] RO_EN = 4'b0001,
  parameter bit POST_WRITES = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [22:0]               cpu_addr,
  input  logic [15:0]               cpu_dout,
  input  logic [1:0]                cpu_ds_n,
  input  logic                      cpu_rw,
  output logic [15:0]               cpu_din,
  output logic                      cpu_dtack_n,
  output logic [NUM_REGIONS-1:0]    cs_n,
  input  logic [16*NUM_REGIONS-1:0] ext_din,
  input  logic [NUM_REGIONS-1:0]    ext_dtack_n,
  output logic [25:0]               sdr_addr,
  output logic [15:0]               sdr_data,
  output logic [1:0]                sdr_be,
  output logic                      sdr_rw,
  output logic                      sdr_req,
  input  logic                      sdr_ack,
  input  logic [15:0]               sdr_q
);
  localparam int IW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  bridge_state_t state_q, state_d;
  logic [NUM_REGIONS-1:0] hit;
  logic [IW-1:0] idx;
  logic [25:0] dec_addr, addr_q, addr_d;
  logic [15:0] data_q, data_d, din_q, din_d;
  logic [1:0] be_q, be_d;
  logic unmapped, ds_idle, ds_idle_q, start, pend, ro_wr, issue;
  logic req_q, req_d, rw_q, rw_d;

  cpu_region_decode #(
    .NR(NUM_REGIONS), .IW(IW), .BASE(REGION_BASE), .MASK(REGION_MASK), .SDR(REGION_SDR)
  ) u_decode (
    .addr({cpu_addr, 1'b0}), .hit(hit), .idx(idx), .sdr_addr(dec_addr), .unmapped(unmapped)
  );

  assign ds_idle = &cpu_ds_n;
  assign start = ds_idle_q & ~ds_idle;
  assign pend = req_q ^ sdr_ack;
  assign ro_wr = ~cpu_rw & RO_EN[idx];

  always_comb begin
    state_d = state_q;
    din_d = din_q;
    issue = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = !start ? IDLE : (unmapped || ro_wr) ? ACK : !SDR_EN[idx] ? EXT : pend ? WAITP : REQ;
        issue = start & ~unmapped & ~ro_wr & SDR_EN[idx] & ~pend;
        din_d = (start & unmapped) ? 16'hFFFF : din_q;
      end
      WAITP: begin
        state_d = ds_idle ? IDLE : pend ? WAITP : REQ;
        issue = ~ds_idle & ~pend;
      end
      // an aborted cycle leaves the request in flight; pend keeps the next issue waiting for it
      REQ: begin
        state_d = ds_idle ? IDLE : (~pend || (~rw_q && POST_WRITES)) ? ACK : REQ;
        din_d = (~ds_idle & ~pend & rw_q) ? sdr_q : din_q;
      end
      default: state_d = ds_idle ? IDLE : state_q;
    endcase
    req_d = issue ? ~req_q : req_q;
    addr_d = issue ? dec_addr : addr_q;
    data_d = issue ? cpu_dout : data_q;
    be_d = issue ? ~cpu_ds_n : be_q;
    rw_d = issue ? cpu_rw : rw_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ds_idle_q <= 1'b1;
      din_q <= 16'hFFFF;
      req_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      be_q <= '0;
      rw_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ds_idle_q <= ds_idle;
      din_q <= din_d;
      req_q <= req_d;
      addr_q <= addr_d;
      data_q <= data_d;
      be_q <= be_d;
      rw_q <= rw_d;
    end
  end

  assign cpu_dtack_n = (state_q == ACK) ? ds_idle : (state_q == EXT) ? (ds_idle | ext_dtack_n[idx]) : 1'b1;
  assign cpu_din = (state_q == EXT) ? ext_din[16*idx +: 16] : din_q;
  assign cs_n = ~(hit & {NUM_REGIONS{~ds_idle}});
  assign sdr_addr = addr_q;
  assign sdr_data = data_q;
  assign sdr_be = be_q;
  assign sdr_rw = rw_q;
  assign sdr_req = req_q;
endmodule

// File: tb/tb_cpu_sdr_bridge.sv
// tb_cpu_sdr_bridge: directed table, hand-written corner sequences and randomized accesses
// against a memory-map reference model, with a toggle-handshake SDRAM responder.
module tb_cpu_sdr_bridge;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [15:0] cpu_dout = '0;
  logic [1:0] cpu_ds_n = 2'b11;
  logic cpu_rw = 1'b1;
  logic [15:0] cpu_din;
  logic cpu_dtack_n;
  logic [3:0] cs_n;
  logic [63:0] ext_din = '0;
  logic [3:0] ext_dtack_n = '0;
  logic [25:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0] sdr_be;
  logic sdr_rw, sdr_req;
  logic sdr_ack = 1'b0;
  logic [15:0] sdr_q = '0;

  always #5 clk = ~clk;

  cpu_sdr_bridge dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_ds_n(cpu_ds_n),
    .cpu_rw(cpu_rw), .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n), .cs_n(cs_n), .ext_din(ext_din),
    .ext_dtack_n(ext_dtack_n), .sdr_addr(sdr_addr), .sdr_data(sdr_data), .sdr_be(sdr_be),
    .sdr_rw(sdr_rw), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_q(sdr_q)
  );

  int tests = 0, fails = 0;
  int lat = 5, cnt = 0, cycnt = 0, ack_cyc = 0, toggles = 0, viol = 0;
  logic req_prev = 1'b0;
  logic [15:0] sdmem [int];
  logic [15:0] refm [int];

  // reference memory map: base, size, SDRAM byte offset, SDRAM-backed, read-only
  localparam int RB [4] = '{32'h000000, 32'h100000, 32'h800000, 32'hC00000};
  localparam int RS [4] = '{32'h100000, 32'h10000, 32'h10000, 32'h10000};
  localparam int RO [4] = '{32'h400000, 32'h500000, 0, 0};
  localparam bit RSD [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit RRO [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [15:0] dflt(input int w);
    return 16'(w) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic int midx(input logic [23:0] a);
    int ai = int'({8'h00, a});
    for (int i = 0; i < 4; i++)
      if (ai >= RB[i] && ai < RB[i] + RS[i]) return i;
    return -1;
  endfunction

  function automatic int mword(input logic [23:0] a, input int i);
    return (RO[i] + int'({8'h00, a}) - RB[i]) / 2;
  endfunction

  always @(posedge clk) cycnt <= cycnt + 1;

  // SDRAM controller stand-in: completes each request lat cycles after the toggle
  always @(negedge clk) begin
    if (!reset_n) begin
      sdr_ack <= 1'b0;
      cnt <= 0;
    end else if (sdr_req != sdr_ack) begin
      if (cnt + 1 >= lat) begin
        cnt <= 0;
        sdr_ack <= sdr_req;
        ack_cyc <= cycnt;
        if (sdr_rw) sdr_q <= sdmem.exists(int'(sdr_addr)) ? sdmem[int'(sdr_addr)] : dflt(int'(sdr_addr));
        else sdmem[int'(sdr_addr)] = merge(sdmem.exists(int'(sdr_addr)) ? sdmem[int'(sdr_addr)] : dflt(int'(sdr_addr)), sdr_data, sdr_be);
      end else cnt <= cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) req_prev <= 1'b0;
    else if (sdr_req != req_prev) begin
      toggles <= toggles + 1;
      if (sdr_ack != req_prev) viol <= viol + 1;
      req_prev <= sdr_req;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [23:0] a, input logic [1:0] ds, input logic [15:0] d);
    int i = midx(a);
    int w;
    if (i >= 0 && RSD[i] && !RRO[i]) begin
      w = mword(a, i);
      refm[w] = merge(refm.exists(w) ? refm[w] : dflt(w), d, ~ds);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [23:0] a);
    int i = midx(a);
    int w;
    if (i < 0) return 16'hFFFF;
    if (!RSD[i]) return ext_din[16*i +: 16];
    w = mword(a, i);
    return refm.exists(w) ? refm[w] : dflt(w);
  endfunction

  task automatic access(input logic [23:0] a, input bit rw, input logic [1:0] ds, input logic [15:0] d,
                        output logic [15:0] din, output int cyc, output int tog, output logic [3:0] cs,
                        output bit rel_ok, output bit pend, output int dcyc);
    int t0;
    @(negedge clk);
    cpu_addr = a[23:1];
    cpu_rw = rw;
    cpu_dout = d;
    cpu_ds_n = ds;
    t0 = toggles;
    #1 cs = cs_n;
    cyc = 0;
    din = 'x;
    pend = 1'b0;
    dcyc = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!cpu_dtack_n) begin
        cyc = i;
        din = cpu_din;
        pend = sdr_req != sdr_ack;
        dcyc = cycnt;
        break;
      end
    end
    cpu_ds_n = 2'b11;
    #1 rel_ok = cpu_dtack_n;
    @(negedge clk);
    #1 tog = toggles - t0;
  endtask

  typedef struct {
    logic [23:0] a;
    bit rw;
    logic [1:0] ds;
    logic [15:0] d;
    bit chk_din;
    logic [15:0] edin;
    int etog;
    logic [3:0] ecs;
    int maxcyc;
  } vec_t;

  vec_t vt [7];
  logic [15:0] din;
  logic [3:0] cs;
  int cyc, tog, dcyc;
  bit rel, pend;

  initial begin
    vt[0] = '{24'h000100, 1'b1, 2'b00, 16'h0000, 1'b1, 16'hA543, 1, 4'b1110, 6};
    vt[1] = '{24'h000010, 1'b0, 2'b00, 16'h1111, 1'b0, 16'h0000, 0, 4'b1110, 2};
    vt[2] = '{24'h400000, 1'b1, 2'b00, 16'h0000, 1'b1, 16'hFFFF, 0, 4'b1111, 2};
    vt[3] = '{24'h100010, 1'b0, 2'b01, 16'hBEEF, 1'b0, 16'h0000, 1, 4'b1101, 2};
    vt[4] = '{24'h100010, 1'b1, 2'b00, 16'h0000, 1'b1, 16'hBECB, 1, 4'b1101, 14};
    vt[5] = '{24'h000010, 1'b1, 2'b00, 16'h0000, 1'b1, 16'hA5CB, 1, 4'b1110, 14};
    vt[6] = '{24'h400000, 1'b0, 2'b10, 16'h5555, 1'b0, 16'h0000, 0, 4'b1111, 2};

    repeat (3) @(negedge clk);
    chk("reset_dtack_n", cpu_dtack_n, 1);
    chk("reset_din", cpu_din, 16'hFFFF);
    chk("reset_req", sdr_req, 0);
    chk("reset_addr", sdr_addr, 0);
    chk("reset_data", sdr_data, 0);
    chk("reset_be", sdr_be, 0);
    chk("reset_rw", sdr_rw, 1);
    chk("reset_cs_n", cs_n, 4'hF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // ROM read latency: dtack one cycle after ack
    lat = 5;
    access(24'h000100, 1'b1, 2'b00, 16'h0, din, cyc, tog, cs, rel, pend, dcyc);
    chk("rom_rd_din", din, 16'hA543);
    chk("rom_rd_addr", sdr_addr, 26'h200080);
    chk("rom_rd_rw", sdr_rw, 1);
    chk("rom_rd_ack_to_dtack", dcyc - ack_cyc, 1);
    chk("rom_rd_cycles", cyc, lat + 1);
    chk("rom_rd_toggles", tog, 1);

    // external SCN region with slow DTACK
    ext_dtack_n = 4'hF;
    ext_din[47:32] = 16'h1234;
    @(negedge clk);
    cpu_addr = 23'h400000;
    cpu_rw = 1'b1;
    cpu_ds_n = 2'b00;
    #1 chk("ext_cs_n", cs_n, 4'b1011);
    repeat (3) @(negedge clk);
    chk("ext_dtack_wait", cpu_dtack_n, 1);
    ext_dtack_n[2] = 1'b0;
    #1 chk("ext_dtack_follow", cpu_dtack_n, 0);
    chk("ext_din", cpu_din, 16'h1234);
    @(negedge clk);
    cpu_ds_n = 2'b11;
    #1 chk("ext_release", cpu_dtack_n, 1);
    ext_dtack_n = '0;
    @(negedge clk);

    // posted write then immediate read of the same word
    lat = 10;
    access(24'h100002, 1'b0, 2'b10, 16'hBEEF, din, cyc, tog, cs, rel, pend, dcyc);
    model_write(24'h100002, 2'b10, 16'hBEEF);
    chk("post_wr_before_ack", pend, 1);
    chk("post_wr_cycles", cyc, 2);
    chk("post_wr_be", sdr_be, 2'b01);
    chk("post_wr_data", sdr_data, 16'hBEEF);
    chk("post_wr_addr", sdr_addr, 26'h280001);
    chk("post_wr_rw", sdr_rw, 0);
    access(24'h100002, 1'b1, 2'b00, 16'h0, din, cyc, tog, cs, rel, pend, dcyc);
    chk("post_rd_din", din, 16'hA5EF);
    chk("post_rd_toggles", tog, 1);
    chk("post_rd_no_timeout", cyc > 0, 1);

    lat = 4;
    foreach (vt[k]) begin
      access(vt[k].a, vt[k].rw, vt[k].ds, vt[k].d, din, cyc, tog, cs, rel, pend, dcyc);
      if (!vt[k].rw) model_write(vt[k].a, vt[k].ds, vt[k].d);
      if (vt[k].chk_din) chk($sformatf("vec%0d_din", k), din, vt[k].edin);
      chk($sformatf("vec%0d_toggles", k), tog, vt[k].etog);
      chk($sformatf("vec%0d_cs_n", k), cs, vt[k].ecs);
      chk($sformatf("vec%0d_cycles_ok", k), cyc > 0 && cyc <= vt[k].maxcyc, 1);
      chk($sformatf("vec%0d_release", k), rel, 1);
    end

    // aborted read: request completes in background, next read still correct
    lat = 8;
    @(negedge clk);
    cpu_addr = 23'h000180;
    cpu_rw = 1'b1;
    cpu_ds_n = 2'b00;
    repeat (2) @(negedge clk);
    cpu_ds_n = 2'b11;
    repeat (2) @(negedge clk);
    access(24'h000400, 1'b1, 2'b00, 16'h0, din, cyc, tog, cs, rel, pend, dcyc);
    chk("abort_next_din", din, model_read(24'h000400));
    chk("abort_next_cycles_ok", cyc > 0, 1);

    // reset in the middle of an SDRAM request
    lat = 20;
    @(negedge clk);
    cpu_addr = 23'h000100;
    cpu_rw = 1'b1;
    cpu_ds_n = 2'b00;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_req", sdr_req, 0);
    chk("rst_mid_dtack_n", cpu_dtack_n, 1);
    chk("rst_mid_din", cpu_din, 16'hFFFF);
    @(negedge clk);
    cpu_ds_n = 2'b11;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    lat = 5;
    access(24'h000200, 1'b1, 2'b00, 16'h0, din, cyc, tog, cs, rel, pend, dcyc);
    chk("rst_after_din", din, 16'hA4C3);
    chk("rst_after_toggles", tog, 1);
    chk("rst_after_cycles", cyc, lat + 1);

    for (int n = 0; n < 150; n++) begin
      int r = $urandom_range(0, 4);
      logic [23:0] a;
      bit rw = 1'($urandom);
      logic [1:0] ds = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
      logic [15:0] d = 16'($urandom);
      int i;
      logic [15:0] exp;
      lat = $urandom_range(1, 6);
      ext_din = {$urandom, $urandom};
      a = (r == 4) ? 24'h400000 + (24'($urandom) & 24'h00FFFE)
        : (r == 0) ? 24'($urandom) & 24'h0FFFFE
        : 24'(RB[r]) + (24'($urandom) & 24'h00FFFE);
      i = midx(a);
      exp = model_read(a);
      access(a, rw, ds, d, din, cyc, tog, cs, rel, pend, dcyc);
      if (rw) chk($sformatf("rnd%0d_din@%06h", n, a), din, exp);
      else model_write(a, ds, d);
      chk($sformatf("rnd%0d_toggles", n), tog, (i >= 0 && RSD[i] && !(!rw && RRO[i])) ? 1 : 0);
      chk($sformatf("rnd%0d_cs_n", n), cs, i < 0 ? 4'hF : ~(4'b0001 << i));
      chk($sformatf("rnd%0d_dtack_seen", n), cyc > 0, 1);
      chk($sformatf("rnd%0d_release", n), rel, 1);
    end

    repeat (10) @(negedge clk);
    chk("no_double_toggle", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
